pwm_led_ctrl: RTL and testbench
===============================

# pwm_led_ctrl

Parametrised, bus-programmable PWM output block that supersedes static general-purpose output bits for the board LEDs and RGB LEDs. It sits as a device on the system bus of `ibex_super_system`, alongside SRAM and the UART. It drives `NumChannels` PWM outputs from one shared timebase. Each channel's duty cycle is double-buffered so that updates never produce a glitch within a period.

## Interface
- `NumChannels`, default 16: number of PWM outputs, 1..64.
- `CtrWidth`, default 8: width of the period counter and of the duty values.
- `PrescaleWidth`, default 16: width of the prescaler reload value.

- `clk_sys_i`  in  1  system clock.
- `rst_sys_i`  in  1  reset, synchronous, active-high; the only clock and the only reset of the block.
- `req_i`  in  1  bus request; every request is accepted in the cycle it is asserted.
- `we_i`  in  1  write enable.
- `be_i`  in  4  byte enables.
- `addr_i`  in  32  byte address; only `addr_i[11:2]` is decoded.
- `wdata_i`  in  32  write data.
- `rvalid_o`  out  1  response valid, one cycle after `req_i`, for both reads and writes.
- `rdata_o`  out  32  read data, valid while `rvalid_o` is high; 0 otherwise.
- `pwm_o`  out  NumChannels  PWM outputs, registered.

## Operation
- Register map (word offsets, in bytes):
  - 0x000 CTRL: bit0 EN, bit1 INV.
  - 0x004 PRESCALE: `[PrescaleWidth-1:0]`.
  - 0x008 PERIOD: `[CtrWidth-1:0]`, top count.
  - 0x00C STATUS: read-only; bit0 PEND is 1 when any shadow duty differs from its active duty.
  - 0x100 + 4*i DUTY[i]: `[CtrWidth-1:0]`, writes the shadow register; reads return the shadow.
- Register reset values: all 0, except PERIOD, which resets to all-ones.
- Writes honour `be_i` per byte. Bits beyond a field's width are ignored on write and read back as 0.
- Unmapped offsets and channel indices ≥ NumChannels: reads return 0 and writes are dropped. Neither raises an error.
- Prescaler: `psc` counts from 0 up to PRESCALE. A one-cycle `tick` fires when `psc == PRESCALE`, and `psc` returns to 0 in the same cycle. PRESCALE=0 therefore gives a tick every cycle.
- Period counter `ctr` advances on each `tick`.
  - When `ctr >= PERIOD` at a tick, `ctr` becomes 0 and a one-cycle `wrap` pulse fires.
  - Using `>=` means that lowering PERIOD below the current `ctr` forces a wrap on the next tick.
- On `wrap`, every active duty is loaded from its shadow.
- With EN=0:
  - `psc` and `ctr` are held at 0.
  - Active duties continuously follow their shadows.
  - Every `pwm_o` bit equals INV.
- With EN=1: `pwm_o[i] <= (ctr < active_duty[i]) ^ INV`.
  - duty=0 gives constant low.
  - duty > PERIOD gives constant high.
- A DUTY write in the same cycle as `wrap` does not reach active. Active loads the old shadow, and the new value takes effect at the following wrap.
- Rising edge of EN: counting starts from `psc=0`, `ctr=0`, with active duties already equal to the shadows.
- Reset mid-operation: all state returns to reset values in the next cycle. Any response pending on `rvalid_o` is dropped.

## Timing
- Output reset values: `pwm_o`=0, `rvalid_o`=0, `rdata_o`=0.
- Bus: `req_i` in cycle N gives `rvalid_o`=1 in cycle N+1. Back-to-back requests produce back-to-back responses. A write takes effect at the N→N+1 clock edge.
- Output latency: `pwm_o` reflects the `ctr`/duty state one cycle after it occurs.
- A CTRL write that sets EN at edge N causes the first `pwm_o` change at edge N+1.
- PWM period is (PERIOD+1)·(PRESCALE+1) cycles. Output resolution is PERIOD+1 steps.

## Structure
- Package `pwm_led_pkg` holds:
  - register offset constants;
  - CTRL bit-position constants;
  - the reset value of PERIOD, as a function of CtrWidth.
- Sub-module `pwm_led_timebase` contains the prescaler and period counter. Inputs: `en`, `prescale`, `period`. Outputs: `ctr`, `wrap`.
- Top module `pwm_led_ctrl` contains:
  - register file and bus decode;
  - shadow and active duty arrays;
  - per-channel comparators;
  - output flops.

## Test plan
- Reset defaults: after reset, read PERIOD → 0xFF with `rvalid_o` one cycle after `req_i`. Read CTRL, DUTY[0] and STATUS → 0. `pwm_o` = 0.
- Basic PWM: PRESCALE=0, PERIOD=9, DUTY[3]=3, EN=1 → `pwm_o[3]` repeats 3 cycles high, 7 cycles low. Period is 10 cycles.
- Glitch-free update: set DUTY[0]=2, then write DUTY[0]=8 mid-period.
  - STATUS.PEND reads 1 until the next wrap, then 0.
  - High time changes 2→8 only in the period after that wrap.
- Boundaries:
  - DUTY=0 → constant 0.
  - DUTY=PERIOD+1 → constant 1.
  - INV=1 inverts both.
  - Lowering PERIOD from 9 to 4 while `ctr`=7 → wrap on the next tick.
- Prescale and byte enables:
  - PRESCALE=3, PERIOD=3 → period of 16 cycles.
  - Write 0xAAAA_AA05 with `be_i`=0001 to DUTY[1] → reads back 0x05.
  - Write to offset 0x1F0 is dropped; a read there returns 0.
- Reset mid-operation: assert `rst_sys_i` for 1 cycle while running → the next cycle has `pwm_o`=0, CTRL=0, PERIOD=0xFF, and no `rvalid_o`.

Source files
------------

// File: rtl/pwm_led_pkg.sv
// Shared constants and helpers for the bus-programmable PWM LED block.
// Offsets are word addresses (byte address bits [11:2]).
package pwm_led_pkg;

    localparam logic [9:0] REG_CTRL     = 10'h000;
    localparam logic [9:0] REG_PRESCALE = 10'h001;
    localparam logic [9:0] REG_PERIOD   = 10'h002;
    localparam logic [9:0] REG_STATUS   = 10'h003;
    // DUTY[i] lives at byte 0x100 + 4*i, so byte address bits [11:8] select the page.
    localparam logic [3:0] REG_DUTY_PAGE = 4'h1;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_INV = 1;

    function automatic logic [31:0] period_rst(int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [31:0] be_merge(logic [31:0] old, logic [31:0] wdata,
                                             logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_led_timebase.sv
// Shared PWM timebase: prescaler producing ticks, and the period counter
// that wraps when it reaches (or has overshot) the programmed top count.
module pwm_led_timebase #(
    parameter int CtrWidth      = 8,
    parameter int PrescaleWidth = 16
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_sys_i,
    input  logic                     en,
    input  logic [PrescaleWidth-1:0] prescale,
    input  logic [CtrWidth-1:0]      period,
    output logic [CtrWidth-1:0]      ctr,
    output logic                     wrap
);

    logic [PrescaleWidth-1:0] psc;
    logic                     tick;

    assign tick = en && (psc == prescale);
    // >= so that shrinking PERIOD below the running count still wraps promptly.
    assign wrap = tick && (ctr >= period);

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i || !en) begin
            psc <= '0;
            ctr <= '0;
        end else begin
            psc <= tick ? '0 : psc + PrescaleWidth'(1);
            if (tick) ctr <= wrap ? '0 : ctr + CtrWidth'(1);
        end
    end

endmodule

// File: rtl/pwm_led_ctrl.sv
// Bus-programmable multi-channel PWM for board LEDs: register file, double-
// buffered duty arrays, per-channel comparators and registered outputs.
module pwm_led_ctrl
    import pwm_led_pkg::*;
#(
    parameter int NumChannels   = 16,
    parameter int CtrWidth      = 8,
    parameter int PrescaleWidth = 16
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_sys_i,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [3:0]             be_i,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            wdata_i,
    output logic                   rvalid_o,
    output logic [31:0]            rdata_o,
    output logic [NumChannels-1:0] pwm_o
);

    logic [1:0]                            ctrl;
    logic [PrescaleWidth-1:0]              prescale;
    logic [CtrWidth-1:0]                   period;
    logic [NumChannels-1:0][CtrWidth-1:0]  shadow;
    logic [NumChannels-1:0][CtrWidth-1:0]  active;
    logic [CtrWidth-1:0]                   ctr;
    logic                                  wrap;
    logic                                  en, inv, pend, wr;
    logic [9:0]                            waddr;
    logic                                  duty_sel;
    logic [5:0]                            duty_idx;
    logic [31:0]                           rd;
    logic [NumChannels-1:0]                pwm_nxt;
    logic                                  unused_addr;

    assign en          = ctrl[CTRL_EN];
    assign inv         = ctrl[CTRL_INV];
    assign waddr       = addr_i[11:2];
    assign duty_sel    = (addr_i[11:8] == REG_DUTY_PAGE);
    assign duty_idx    = addr_i[7:2];
    assign wr          = req_i && we_i;
    assign pend        = (shadow != active);
    assign unused_addr = ^{addr_i[31:12], addr_i[1:0]};

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            ctrl     <= '0;
            prescale <= '0;
            period   <= CtrWidth'(period_rst(CtrWidth));
            shadow   <= '0;
        end else if (wr) begin
            case (waddr)
                REG_CTRL:     ctrl     <= 2'(be_merge(32'(ctrl), wdata_i, be_i));
                REG_PRESCALE: prescale <= PrescaleWidth'(be_merge(32'(prescale), wdata_i, be_i));
                REG_PERIOD:   period   <= CtrWidth'(be_merge(32'(period), wdata_i, be_i));
                default: ;
            endcase
            for (int i = 0; i < NumChannels; i++) begin
                if (duty_sel && duty_idx == 6'(i))
                    shadow[i] <= CtrWidth'(be_merge(32'(shadow[i]), wdata_i, be_i));
            end
        end
    end

    // Active duties track shadows while idle so enabling starts from fresh values;
    // a shadow write at the wrap edge itself lands one period later.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i)        active <= '0;
        else if (!en || wrap) active <= shadow;
    end

    pwm_led_timebase #(
        .CtrWidth      (CtrWidth),
        .PrescaleWidth (PrescaleWidth)
    ) u_timebase (
        .clk_sys_i (clk_sys_i),
        .rst_sys_i (rst_sys_i),
        .en        (en),
        .prescale  (prescale),
        .period    (period),
        .ctr       (ctr),
        .wrap      (wrap)
    );

    for (genvar i = 0; i < NumChannels; i++) begin : g_ch
        assign pwm_nxt[i] = en ? ((ctr < active[i]) ^ inv) : inv;
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) pwm_o <= '0;
        else           pwm_o <= pwm_nxt;
    end

    always_comb begin
        rd = '0;
        case (waddr)
            REG_CTRL:     rd = 32'(ctrl);
            REG_PRESCALE: rd = 32'(prescale);
            REG_PERIOD:   rd = 32'(period);
            REG_STATUS:   rd = {31'b0, pend};
            default: ;
        endcase
        for (int i = 0; i < NumChannels; i++) begin
            if (duty_sel && duty_idx == 6'(i)) rd = 32'(shadow[i]);
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= (req_i && !we_i) ? rd : '0;
        end
    end

endmodule

// File: tb/tb_pwm_led_ctrl.sv
// Directed bench for pwm_led_ctrl: register vector table plus hand-timed
// sequences for PWM waveforms, double-buffering, wrap and reset corners.
module tb_pwm_led_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic [15:0] pwm;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_led_ctrl dut (
        .clk_sys_i (clk),
        .rst_sys_i (rst),
        .req_i     (req),
        .we_i      (we),
        .be_i      (be),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .pwm_o     (pwm)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
    endtask

    task automatic clr_req();
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    endtask

    task automatic wrb(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        set_req(1'b1, a, d, b);
        step();
        clr_req();
        chk($sformatf("wr_rvalid@%0h", a), rvalid, 1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wrb(a, d, 4'hF);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        set_req(1'b0, a, '0, '0);
        step();
        clr_req();
        chk({name, "_rvalid"}, rvalid, 1);
        chk(name, rdata, exp);
    endtask

    // pwm sampled m+1 cycles after the enabling edge reflects counter state m.
    function automatic logic pwm_ref(int m, int per, int psc, int duty);
        return ((m / (psc + 1)) % (per + 1)) < duty;
    endfunction

    initial begin
        logic [63:0] act, exp;
        logic        acc_or, acc_and;
        int          d, m, c;

        rst = 1'b1;
        clr_req();
        repeat (3) step();
        chk("rst_pwm", pwm, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
        step();

        // Register map, byte enables, unmapped accesses, back-to-back requests.
        tbl.push_back('{1'b0, 32'h008, 32'h0, 4'h0, 32'h0000_00FF});
        tbl.push_back('{1'b0, 32'h000, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{1'b0, 32'h100, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{1'b0, 32'h00C, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{1'b0, 32'h004, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{1'b0, 32'h010, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{1'b1, 32'h104, 32'hAAAA_AA05, 4'h1, 32'h0});
        tbl.push_back('{1'b0, 32'h104, 32'h0, 4'h0, 32'h0000_0005});
        tbl.push_back('{1'b1, 32'h1F0, 32'h1234_5678, 4'hF, 32'h0});
        tbl.push_back('{1'b0, 32'h1F0, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{1'b1, 32'h004, 32'hFFFF_1234, 4'h3, 32'h0});
        tbl.push_back('{1'b0, 32'h004, 32'h0, 4'h0, 32'h0000_1234});
        tbl.push_back('{1'b1, 32'h004, 32'hABCD_5600, 4'h2, 32'h0});
        tbl.push_back('{1'b0, 32'h004, 32'h0, 4'h0, 32'h0000_5634});
        tbl.push_back('{1'b1, 32'h008, 32'h0000_1209, 4'hF, 32'h0});
        tbl.push_back('{1'b0, 32'h008, 32'h0, 4'h0, 32'h0000_0009});
        tbl.push_back('{1'b1, 32'h000, 32'hFFFF_FFFC, 4'hF, 32'h0});
        tbl.push_back('{1'b0, 32'h000, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{1'b1, 32'h104, 32'h0, 4'hF, 32'h0});
        tbl.push_back('{1'b0, 32'h104, 32'h0, 4'h0, 32'h0});
        tbl.push_back('{1'b1, 32'h004, 32'h0, 4'hF, 32'h0});
        tbl.push_back('{1'b0, 32'h004, 32'h0, 4'h0, 32'h0});
        foreach (tbl[i]) begin
            if (tbl[i].we) wrb(tbl[i].addr, tbl[i].wdata, tbl[i].be);
            else           rd($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp);
        end
        step();
        chk("idle_rvalid", rvalid, 0);
        chk("idle_rdata", rdata, 0);

        // Basic PWM: PERIOD=9, DUTY[3]=3 -> 3 high / 7 low.
        wr(32'h10C, 3);
        wr(32'h000, 1);
        chk("en_latency", pwm[3], 0);
        act = '0; exp = '0; acc_or = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            act[k-1] = pwm[3];
            exp[k-1] = pwm_ref(k - 1, 9, 0, 3);
            acc_or |= |(pwm & 16'hFFF7);
        end
        chk("basic_pwm", act, exp);
        chk("basic_others", acc_or, 0);
        wr(32'h000, 0);
        step();
        chk("disabled_low", pwm, 0);

        // Double-buffered duty: mid-period write, and a write landing on the wrap edge.
        wr(32'h100, 2);
        wr(32'h000, 1);
        act = '0; exp = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 4)  set_req(1'b1, 32'h100, 8, 4'hF);
            if (k == 5 || k == 10 || k == 11) set_req(1'b0, 32'h00C, 0, 4'h0);
            if (k == 20) set_req(1'b1, 32'h100, 5, 4'hF);
            step();
            m = k - 1;
            d = (m < 10) ? 2 : (m < 30) ? 8 : 5;
            act[m] = pwm[0];
            exp[m] = pwm_ref(m, 9, 0, d);
            if (k == 5)  chk("pend_mid", rdata, 1);
            if (k == 10) chk("pend_prewrap", rdata, 1);
            if (k == 11) chk("pend_cleared", rdata, 0);
            clr_req();
        end
        chk("glitch_free", act, exp);
        wr(32'h000, 0);

        // DUTY=0 and DUTY=PERIOD+1, then inverted.
        wr(32'h10C, 0);
        wr(32'h110, 10);
        wr(32'h000, 1);
        acc_or = 1'b0; acc_and = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            acc_or  |= pwm[3];
            acc_and &= pwm[4];
        end
        chk("duty0_low", acc_or, 0);
        chk("dutymax_high", acc_and, 1);
        wr(32'h000, 3);
        step();
        acc_or = 1'b0; acc_and = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            acc_and &= pwm[3];
            acc_or  |= pwm[4];
        end
        chk("inv_duty0_high", acc_and, 1);
        chk("inv_dutymax_low", acc_or, 0);
        wr(32'h000, 2);
        step();
        chk("inv_idle", pwm, 16'hFFFF);
        wr(32'h000, 0);
        step();

        // Lowering PERIOD 9 -> 4 while ctr=7 wraps on the next tick.
        wr(32'h114, 1);
        wr(32'h000, 1);
        act = '0; exp = '0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 7) set_req(1'b1, 32'h008, 4, 4'hF);
            step();
            clr_req();
            m = k - 1;
            c = (m <= 7) ? m : (m - 8) % 5;
            act[m] = pwm[5];
            exp[m] = (c < 1);
        end
        chk("period_shrink", act, exp);
        wr(32'h000, 0);

        // PRESCALE=3, PERIOD=3 -> 16-cycle period.
        wr(32'h004, 3);
        wr(32'h008, 3);
        wr(32'h118, 2);
        wr(32'h000, 1);
        act = '0; exp = '0;
        for (int k = 1; k <= 40; k++) begin
            step();
            act[k-1] = pwm[6];
            exp[k-1] = pwm_ref(k - 1, 3, 3, 2);
        end
        chk("prescale_pwm", act, exp);
        chk("pre_reset_high", pwm[4], 1);

        // Reset mid-operation with a request in flight.
        set_req(1'b0, 32'h000, 0, 4'h0);
        rst = 1'b1;
        step();
        clr_req();
        rst = 1'b0;
        chk("midrst_pwm", pwm, 0);
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_rdata", rdata, 0);
        rd("midrst_ctrl", 32'h000, 0);
        rd("midrst_period", 32'h008, 32'hFF);
        rd("midrst_duty4", 32'h110, 0);
        rd("midrst_prescale", 32'h004, 0);
        step();
        chk("midrst_pwm_hold", pwm, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
